// File: rtl/neuro_pkg.sv
`default_nettype none
// ============================================================================
// neuro_pkg
// Shared state encoding and weight-width default for the neuroevolution stages.
// Revision: 1.0
// ============================================================================
package neuro_pkg;

  localparam int WEIGHT_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_add.sv
`default_nettype none
// ============================================================================
// sat_add
// Combinational signed weight + signed 4-bit delta, clamped to the weight range.
// Revision: 1.0
// ============================================================================
module sat_add #(
  parameter int WEIGHT_W = 8
) (
  input  logic [WEIGHT_W-1:0] a,
  input  logic [3:0]          delta,
  output logic [WEIGHT_W-1:0] sum
);

  logic [WEIGHT_W:0] wide;

  assign wide = {a[WEIGHT_W-1], a} + {{(WEIGHT_W-3){delta[3]}}, delta};

  // Top two bits disagree only on overflow; the top bit then gives the direction.
  always_comb begin
    sum = wide[WEIGHT_W-1:0];
    if (wide[WEIGHT_W] != wide[WEIGHT_W-1]) begin
      sum = wide[WEIGHT_W] ? {1'b1, {(WEIGHT_W-1){1'b0}}}
                           : {1'b0, {(WEIGHT_W-1){1'b1}}};
    end
  end

endmodule
`default_nettype wire

// File: rtl/genome_mutator.sv
`default_nettype none
// ============================================================================
// genome_mutator
// Walks the genome RAM, randomly perturbing weights in place with saturation.
// Revision: 1.0
// ============================================================================
module genome_mutator
  import neuro_pkg::*;
#(
  parameter int WEIGHT_W   = WEIGHT_W_DEFAULT,
  parameter int GENOME_LEN = 64,
  parameter int ADDR_W     = 6
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [7:0]          mut_thresh,
  input  logic [15:0]         rand_in,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd_en,
  input  logic [WEIGHT_W-1:0] mem_rd_data,
  output logic                mem_wr_en,
  output logic [WEIGHT_W-1:0] mem_wr_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     mut_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(GENOME_LEN - 1);

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [WEIGHT_W-1:0] w;
  logic [7:0]          rand_hi;
  logic [3:0]          delta;
  logic [7:0]          thresh;
  logic                mutate;
  logic [WEIGHT_W-1:0] sat_sum;
  logic                unused_rand;

  assign unused_rand = ^rand_in[7:4];

  sat_add #(
    .WEIGHT_W(WEIGHT_W)
  ) u_sat_add (
    .a    (w),
    .delta(delta),
    .sum  (sat_sum)
  );

  assign mutate = (rand_hi < thresh);

  // Strobes are pure decodes of registered state, so inputs never reach them directly.
  assign mem_addr    = idx;
  assign mem_rd_en   = (state == READ);
  assign mem_wr_en   = (state == WRITE) && mutate;
  assign mem_wr_data = mem_wr_en ? sat_sum : '0;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      idx       <= '0;
      w         <= '0;
      rand_hi   <= '0;
      delta     <= '0;
      thresh    <= '0;
      mut_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= READ;
            idx       <= '0;
            mut_count <= '0;
            thresh    <= mut_thresh;
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          w       <= mem_rd_data;
          rand_hi <= rand_in[15:8];
          delta   <= rand_in[3:0];
          state   <= WRITE;
        end
        WRITE: begin
          if (mutate) begin
            mut_count <= mut_count + (ADDR_W+1)'(1);
          end
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx   <= idx + ADDR_W'(1);
            state <= READ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_genome_mutator.sv
`default_nettype none
// ============================================================================
// tb_genome_mutator
// Scoreboarded bench: 4-weight and 64-weight mutators sharing one RAM model.
// Revision: 1.0
// ============================================================================
module tb_genome_mutator;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn, start, sel, do_load;
  logic [7:0]  mut_thresh;
  logic [15:0] rand_in;
  logic signed [7:0] rd_data;

  logic [1:0] addr4;  logic rd4, wr4, busy4, done4;     logic [7:0] wd4;  logic [2:0] cnt4;
  logic [5:0] addr64; logic rd64, wr64, busy64, done64; logic [7:0] wd64; logic [6:0] cnt64;
  logic start4, start64;

  assign start4  = start & ~sel;
  assign start64 = start & sel;

  genome_mutator #(.WEIGHT_W(8), .GENOME_LEN(4), .ADDR_W(2)) u_dut4 (
    .clock(clock), .resetn(resetn), .start(start4), .mut_thresh(mut_thresh),
    .rand_in(rand_in), .mem_addr(addr4), .mem_rd_en(rd4), .mem_rd_data(rd_data),
    .mem_wr_en(wr4), .mem_wr_data(wd4), .busy(busy4), .done(done4), .mut_count(cnt4)
  );

  genome_mutator #(.WEIGHT_W(8), .GENOME_LEN(64), .ADDR_W(6)) u_dut64 (
    .clock(clock), .resetn(resetn), .start(start64), .mut_thresh(mut_thresh),
    .rand_in(rand_in), .mem_addr(addr64), .mem_rd_en(rd64), .mem_rd_data(rd_data),
    .mem_wr_en(wr64), .mem_wr_data(wd64), .busy(busy64), .done(done64), .mut_count(cnt64)
  );

  logic [5:0] m_addr; logic m_rd, m_wr, m_busy, m_done; logic signed [7:0] m_wd; logic [6:0] m_cnt;

  always_comb begin
    if (sel) begin
      m_addr = addr64; m_rd = rd64; m_wr = wr64; m_wd = wd64;
      m_busy = busy64; m_done = done64; m_cnt = cnt64;
    end else begin
      m_addr = {4'b0, addr4}; m_rd = rd4; m_wr = wr4; m_wd = wd4;
      m_busy = busy4; m_done = done4; m_cnt = {4'b0, cnt4};
    end
  end

  // Genome RAM: one-cycle read latency, write in place.
  logic signed [7:0] ram [64];
  logic signed [7:0] preload [64];
  always @(posedge clock) begin
    if (do_load) begin
      for (int i = 0; i < 64; i++) ram[i] <= preload[i];
    end else begin
      if (m_rd) rd_data <= ram[m_addr];
      if (m_wr) ram[m_addr] <= m_wd;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Random source: value driven after edge e is the one seen in cycle following edge e.
  int          rmode;
  logic [15:0] rconst, lfsr;
  logic [15:0] hist [8192];
  always @(posedge clock) begin
    #1;
    case (rmode)
      1: rand_in = rconst;
      2: begin
        lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        rand_in = lfsr;
      end
      default: rand_in = 16'($urandom);
    endcase
    hist[cyc % 8192] = rand_in;
  end

  typedef struct { int cyc; int addr; int data; } wr_exp_t;
  typedef struct { int cyc; int cnt; } done_exp_t;
  wr_exp_t   wq[$];
  done_exp_t dq[$];
  int ram_exp [64];
  int n_cmp = 0, n_bad = 0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT writes or signals done.
  always @(negedge clock) begin : monitor
    wr_exp_t   e;
    done_exp_t d;
    if (resetn) begin
      if (m_wr) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = wq.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", int'(m_addr), e.addr);
          chk("wr_data", int'(m_wd), e.data);
        end
      end
      if (m_done) begin
        if (dq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          d = dq.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("mut_count", int'(m_cnt), d.cnt);
          chk("writes_missing", wq.size(), 0);
        end
      end
    end
  end

  task automatic wait_cyc(input int target);
    int guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (cyc < target && guard < 1000);
    if (cyc != target) chk("wait_timeout", cyc, target);
  endtask

  task automatic load_ram(input int n, input int v0, input int v1, input int v2, input int v3,
                          input bit rnd);
    for (int j = 0; j < 64; j++) begin
      if (rnd || j >= 4) preload[j] = 8'($urandom);
      else preload[j] = 8'(j == 0 ? v0 : j == 1 ? v1 : j == 2 ? v2 : v3);
      ram_exp[j] = int'(preload[j]);
    end
    @(negedge clock); do_load = 1'b1;
    @(negedge clock); do_load = 1'b0;
    if (n < 0) chk("load_len", n, 0);
  endtask

  // One pass: model each weight from the random word present in its WAIT cycle.
  task automatic run_pass(input int n, input logic [7:0] th, input bit hold,
                          input int rst_at, output int cnt);
    int k, d, s;
    logic [15:0] r;
    wr_exp_t e;
    cnt = 0;
    @(negedge clock);
    start = 1'b1;
    mut_thresh = th;
    @(posedge clock);
    #2;
    k = cyc;
    if (!hold) start = 1'b0;
    mut_thresh = ~th;
    for (int i = 0; i < n; i++) begin
      wait_cyc(k + 3*i + 1);
      if (rst_at == i) begin
        resetn = 1'b0;
        wait_cyc(k + 3*i + 2);
        chk("rst_busy", int'(m_busy), 0);
        chk("rst_rd_en", int'(m_rd), 0);
        chk("rst_wr_en", int'(m_wr), 0);
        chk("rst_done", int'(m_done), 0);
        chk("rst_mut_count", int'(m_cnt), 0);
        resetn = 1'b1;
        break;
      end
      r = hist[(k + 3*i + 1) % 8192];
      if (r[15:8] < th) begin
        d = int'(r[3:0]);
        if (d > 7) d -= 16;
        s = ram_exp[i] + d;
        if (s > 127) s = 127;
        else if (s < -128) s = -128;
        ram_exp[i] = s;
        cnt++;
        e.cyc = k + 3*i + 2; e.addr = i; e.data = s;
        wq.push_back(e);
      end
    end
    if (rst_at < 0) begin
      dq.push_back('{cyc: k + 3*n, cnt: cnt});
      wait_cyc(k + 3*n);
    end
    for (int j = 0; j < n; j++) chk("ram_final", int'(ram[j]), ram_exp[j]);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int c;
    resetn = 1'b0; start = 1'b0; sel = 1'b0; do_load = 1'b0;
    rmode = 0; rconst = 16'h0; lfsr = 16'hACE1; mut_thresh = 8'h0;
    repeat (3) @(negedge clock);
    chk("reset_busy", int'(m_busy), 0);
    chk("reset_done", int'(m_done), 0);
    chk("reset_rd_en", int'(m_rd), 0);
    chk("reset_wr_en", int'(m_wr), 0);
    chk("reset_wr_data", int'(m_wd), 0);
    chk("reset_addr", int'(m_addr), 0);
    chk("reset_mut_count", int'(m_cnt), 0);
    chk("reset_busy64", int'(busy64), 0);
    chk("reset_wr_en64", int'(wr64), 0);
    resetn = 1'b1;

    // Threshold 0 never mutates, even if threshold rises mid-pass.
    load_ram(4, 10, -5, 127, -128, 1'b0);
    run_pass(4, 8'd0, 1'b0, -1, c);
    chk("th0_count", c, 0);
    @(negedge clock);
    chk("count_hold", int'(m_cnt), 0);

    // +7 everywhere: positive saturation on 127.
    rmode = 1; rconst = 16'h0007;
    load_ram(4, 10, -5, 127, -128, 1'b0);
    run_pass(4, 8'd255, 1'b0, -1, c);
    chk("lit0", int'(ram[0]), 17);  chk("lit1", int'(ram[1]), 2);
    chk("lit2", int'(ram[2]), 127); chk("lit3", int'(ram[3]), -121);
    @(negedge clock);
    chk("count_hold4", int'(m_cnt), 4);

    // -8 everywhere: negative saturation.
    rconst = 16'h0008;
    load_ram(4, -128, -126, 0, 5, 1'b0);
    run_pass(4, 8'd255, 1'b0, -1, c);
    chk("neg0", int'(ram[0]), -128); chk("neg1", int'(ram[1]), -128);
    chk("neg2", int'(ram[2]), -8);   chk("neg3", int'(ram[3]), -3);

    // 0xFF in the decision byte never mutates, even at threshold 255.
    rconst = 16'hFF03;
    load_ram(4, 0, 0, 0, 0, 1'b1);
    run_pass(4, 8'd255, 1'b0, -1, c);
    chk("ff_count", c, 0);

    // start held high: back-to-back passes with one idle cycle between.
    rmode = 0;
    load_ram(4, 0, 0, 0, 0, 1'b1);
    run_pass(4, 8'($urandom_range(64, 200)), 1'b1, -1, c);
    run_pass(4, 8'($urandom_range(64, 200)), 1'b0, -1, c);

    // Reset during WAIT of weight 2.
    rmode = 1; rconst = 16'h0007;
    load_ram(4, 10, -5, 127, -128, 1'b0);
    run_pass(4, 8'd255, 1'b0, 2, c);
    repeat (4) @(negedge clock);
    chk("rst_idle_busy", int'(m_busy), 0);
    chk("rst_w0", int'(ram[0]), 17);  chk("rst_w1", int'(ram[1]), 2);
    chk("rst_w2", int'(ram[2]), 127); chk("rst_w3", int'(ram[3]), -128);

    // 64-weight genome driven by an LFSR random source.
    @(negedge clock); sel = 1'b1; rmode = 2;
    load_ram(64, 0, 0, 0, 0, 1'b1);
    run_pass(64, 8'd128, 1'b0, -1, c);
    run_pass(64, 8'd128, 1'b0, -1, c);
    rmode = 0;
    run_pass(64, 8'($urandom), 1'b0, -1, c);
    run_pass(64, 8'd255, 1'b0, -1, c);

    repeat (3) @(negedge clock);
    chk("queues_empty", wq.size() + dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/genome_mutator.md
# genome_mutator

Sequencer that mutates one genome stored in weight RAM, using the free-running 16-bit pseudo-random word from the LFSR generator upstream. On `start` it reads each weight and draws a mutate/no-mutate decision and a small signed delta from the random word. Mutated weights get a saturating add and are written back in place. It sits between the random source and the genome memory in the neuroevolution loop.

## Interface
- `WEIGHT_W`, 8: signed weight width, two's complement, ≥ 5.
- `GENOME_LEN`, 64: number of weights in the genome, ≥ 1.
- `ADDR_W`, 6: RAM address width; `2**ADDR_W >= GENOME_LEN`.

Ports:
- `clock`  in  1: clock.
- `resetn`  in  1: reset, synchronous, active-low.
- `start`  in  1: begin a pass; sampled only in IDLE.
- `mut_thresh`  in  8: mutation threshold, latched at start.
- `rand_in`  in  16: random word; changes every cycle; no handshake.
- `mem_addr`  out  ADDR_W: RAM address for read and write.
- `mem_rd_en`  out  1: RAM read strobe.
- `mem_rd_data`  in  WEIGHT_W: RAM read data, valid the cycle after `mem_rd_en`.
- `mem_wr_en`  out  1: RAM write strobe.
- `mem_wr_data`  out  WEIGHT_W: write data.
- `busy`  out  1: high from the cycle after start is accepted through DONE.
- `done`  out  1: one-cycle pulse at the end of a pass.
- `mut_count`  out  ADDR_W+1: number of weights mutated in the last or current pass.

## Operation
- States and transitions:
  - IDLE → READ on `start`. On that edge: `idx`←0, `mut_count`←0, latch `mut_thresh`.
  - READ → WAIT.
  - WAIT → WRITE.
  - WRITE → READ with `idx`+1 if `idx` < GENOME_LEN-1, else → DONE.
  - DONE → IDLE.
- READ: `mem_rd_en`=1, `mem_addr`=`idx`.
- WAIT: register `mem_rd_data` as `w`. Sample `rand_in` into `r`, one sample per weight.
- WRITE: `mutate` = (`r[15:8]` < latched thresh, unsigned compare).
  - delta = `r[3:0]` as signed, range -8..+7, sign-extended to WEIGHT_W.
  - If `mutate`: `mem_wr_en`=1, `mem_addr`=`idx`, `mem_wr_data`=sat(`w`+delta), and `mut_count` increments.
  - Else no write.
- Saturation: compute the sum at WEIGHT_W+1 bits, then clamp to [-2^(W-1), 2^(W-1)-1].
- `start` in any state other than IDLE is ignored. `mut_thresh` changes mid-pass have no effect.
- Threshold extremes: `mut_thresh`=0 never mutates. 255 mutates unless `r[15:8]`=0xFF.
- All memory strobes are decoded from registered state only; no combinational input→output path.
- `mut_count` holds its value after DONE until the next accepted start.

## Timing
- Reset values: state IDLE; `mem_addr`=0, `mem_rd_en`=0, `mem_wr_en`=0, `mem_wr_data`=0, `busy`=0, `done`=0, `mut_count`=0.
- Reset mid-pass: next cycle is IDLE with all strobes low. A partially mutated genome is acceptable; no write is issued after reset asserts.
- 3 cycles per weight.
- Start accepted at edge k: first `mem_rd_en` in cycle k+1; `done` high in cycle k+3·GENOME_LEN+1.
- A new `start` is accepted in the cycle `done` is high +1 (IDLE), giving back-to-back passes with one idle cycle.
- Read-after-write to the same address never occurs within a pass.

## Structure
- Shared package `neuro_pkg`: state enum (IDLE, READ, WAIT, WRITE, DONE) and the default `WEIGHT_W` constant, reused by the crossover and evaluation stages.
- One sub-module: `sat_add`, a combinational signed saturating add of WEIGHT_W + 4-bit delta, reusable elsewhere.
- Remainder is a single FSM plus `idx`, `w`, `r`, thresh and count registers, in about 150–250 lines.

## Test plan
- GENOME_LEN=4, RAM {10,-5,127,-128}, `mut_thresh`=0 → zero `mem_wr_en`; `done` exactly 13 cycles after start; `mut_count`=0.
- Same RAM, `mut_thresh`=255, `rand_in` forced to 0x0007 → RAM becomes {17,2,127,-121}; `mut_count`=4.
- `rand_in` forced to 0x0008, RAM {-128,-126,0,5} → {-128,-128,-8,-3}; checks negative saturation.
- `start` held high throughout a pass → exactly one pass per accepted start; second pass begins the cycle after IDLE.
- `resetn` low during WAIT of weight 2 → next cycle IDLE with strobes low; weights 2..3 unchanged; `busy`=0 and `mut_count`=0.
- LFSR model connected, `mut_thresh`=128, GENOME_LEN=64 → each write matches the reference model from sampled `r`; `mut_count` equals the model count.
